// File: rtl/cache_state_dir.sv
// Valid/dirty/round-robin state directory for a set-associative cache, with a
// sequential flush engine that hands dirty lines to a writeback port one at a time.
module cache_state_dir #(
    parameter int SET_BITS = 8,
    parameter int WAY_BITS = 1,
    localparam int WAYS = 1 << WAY_BITS,
    localparam int WW   = (WAY_BITS > 0) ? WAY_BITS : 1
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [SET_BITS-1:0] lk_set,
    output logic [WAYS-1:0]     lk_valid,
    output logic [WAYS-1:0]     lk_dirty,
    output logic [WW-1:0]       victim_way,
    input  logic                upd_en,
    input  logic [SET_BITS-1:0] upd_set,
    input  logic [WW-1:0]       upd_way,
    input  logic [1:0]          upd_op,
    input  logic                flush_start,
    input  logic                flush_inv,
    output logic                flush_busy,
    output logic                flush_done,
    output logic                wb_valid,
    input  logic                wb_ready,
    output logic [SET_BITS-1:0] wb_set,
    output logic [WW-1:0]       wb_way
);

    localparam int SETS = 1 << SET_BITS;

    // state | meaning
    // IDLE  | no flush in progress, updates accepted
    // SCAN  | examining set scan_idx for dirty lines
    // WB    | writeback request outstanding for (scan_idx, wb_way_r)
    // DONE  | one-cycle flush completion pulse
    typedef enum logic [1:0] {IDLE, SCAN, WB, DONE} state_t;

    state_t              state, state_n;
    logic [WAYS-1:0]     v_mem  [SETS];
    logic [WAYS-1:0]     d_mem  [SETS];
    logic [WW-1:0]       rr_mem [SETS];
    logic [SET_BITS-1:0] scan_idx;
    logic                inv_lat;
    logic [WW-1:0]       wb_way_r;
    logic [WAYS-1:0]     scan_vd;
    logic [WW-1:0]       scan_way;
    logic [WW-1:0]       upd_idx;
    logic [WW-1:0]       rr_inc;
    logic                found;

    assign lk_valid   = v_mem[lk_set];
    assign lk_dirty   = d_mem[lk_set];
    assign scan_vd    = v_mem[scan_idx] & d_mem[scan_idx];
    assign flush_busy = (state == SCAN) || (state == WB);
    assign flush_done = (state == DONE);
    assign wb_valid   = (state == WB);
    assign wb_set     = scan_idx;
    assign wb_way     = wb_way_r;
    assign upd_idx    = upd_way & WW'(WAYS - 1);
    assign rr_inc     = (WAY_BITS == 0) ? '0 : rr_mem[upd_set] + 1'b1;

    always_comb begin
        victim_way = rr_mem[lk_set];
        found      = 1'b0;
        for (int w = 0; w < WAYS; w++) begin
            if (!found && !lk_valid[w]) begin
                victim_way = WW'(w);
                found      = 1'b1;
            end
        end
    end

    always_comb begin
        scan_way = '0;
        for (int w = WAYS - 1; w >= 0; w--) begin
            if (scan_vd[w]) scan_way = WW'(w);
        end
    end

    always_comb begin
        state_n = state;
        case (state)
            IDLE: if (flush_start) state_n = SCAN;
            SCAN: begin
                if (scan_vd != '0)      state_n = WB;
                else if (scan_idx == '1) state_n = DONE;
            end
            WB:   if (wb_ready) state_n = SCAN;
            DONE: state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int s = 0; s < SETS; s++) begin
                v_mem[s]  <= '0;
                d_mem[s]  <= '0;
                rr_mem[s] <= '0;
            end
            state    <= IDLE;
            scan_idx <= '0;
            inv_lat  <= 1'b0;
            wb_way_r <= '0;
        end else begin
            state <= state_n;
            case (state)
                IDLE: begin
                    if (flush_start) begin
                        scan_idx <= '0;
                        inv_lat  <= flush_inv;
                    end
                end
                SCAN: begin
                    if (scan_vd != '0) begin
                        wb_way_r <= scan_way;
                    end else begin
                        if (inv_lat) begin
                            v_mem[scan_idx] <= '0;
                            d_mem[scan_idx] <= '0;
                        end
                        if (scan_idx != '1) scan_idx <= scan_idx + 1'b1;
                    end
                end
                WB: begin
                    // Stay on the same set: it may hold further dirty ways.
                    if (wb_ready) begin
                        d_mem[scan_idx][wb_way_r] <= 1'b0;
                        if (inv_lat) v_mem[scan_idx][wb_way_r] <= 1'b0;
                    end
                end
                default: ;
            endcase
            if (upd_en && !flush_busy) begin
                case (upd_op)
                    2'b00: begin
                        v_mem[upd_set][upd_idx] <= 1'b1;
                        d_mem[upd_set][upd_idx] <= 1'b0;
                        if (upd_idx == rr_mem[upd_set]) rr_mem[upd_set] <= rr_inc;
                    end
                    2'b01: if (v_mem[upd_set][upd_idx]) d_mem[upd_set][upd_idx] <= 1'b1;
                    2'b10: d_mem[upd_set][upd_idx] <= 1'b0;
                    default: begin
                        v_mem[upd_set][upd_idx] <= 1'b0;
                        d_mem[upd_set][upd_idx] <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_cache_state_dir.sv
// Directed bench for cache_state_dir: lookup/victim behaviour, update ops,
// flush with writeback handshake, flush timing and reset abort.
module tb_cache_state_dir;

    logic       clk = 1'b0;
    logic       reset;
    logic [7:0] lk_set;
    logic [1:0] lk_valid, lk_dirty;
    logic [0:0] victim_way;
    logic       upd_en;
    logic [7:0] upd_set;
    logic [0:0] upd_way;
    logic [1:0] upd_op;
    logic       flush_start, flush_inv, flush_busy, flush_done;
    logic       wb_valid, wb_ready;
    logic [7:0] wb_set;
    logic [0:0] wb_way;

    int n_chk  = 0;
    int n_fail = 0;

    cache_state_dir #(.SET_BITS(8), .WAY_BITS(1)) dut (
        .clk(clk), .reset(reset), .lk_set(lk_set), .lk_valid(lk_valid),
        .lk_dirty(lk_dirty), .victim_way(victim_way), .upd_en(upd_en),
        .upd_set(upd_set), .upd_way(upd_way), .upd_op(upd_op),
        .flush_start(flush_start), .flush_inv(flush_inv),
        .flush_busy(flush_busy), .flush_done(flush_done),
        .wb_valid(wb_valid), .wb_ready(wb_ready), .wb_set(wb_set), .wb_way(wb_way)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic upd(input logic [7:0] s, input logic w, input logic [1:0] op);
        upd_en = 1'b1; upd_set = s; upd_way = w; upd_op = op;
        tick();
        upd_en = 1'b0;
    endtask

    task automatic look(input string tag, input logic [7:0] s,
                        input logic [1:0] v, input logic [1:0] d, input logic vw);
        lk_set = s;
        #1;
        chk({tag, "_valid"}, 32'(lk_valid), 32'(v));
        chk({tag, "_dirty"}, 32'(lk_dirty), 32'(d));
        chk({tag, "_victim"}, 32'(victim_way), 32'(vw));
    endtask

    logic [7:0] exp_set [3] = '{8'd2, 8'd2, 8'd200};
    logic       exp_way [3] = '{1'b0, 1'b1, 1'b1};

    initial begin
        int n_wb, n_done, wb_cnt, n, seen;
        reset = 1'b1; lk_set = '0; upd_en = 1'b0; upd_set = '0; upd_way = '0;
        upd_op = '0; flush_start = 1'b0; flush_inv = 1'b0; wb_ready = 1'b0;
        tick(); tick();
        reset = 1'b0;
        chk("rst_busy", 32'(flush_busy), 0);
        chk("rst_done", 32'(flush_done), 0);
        chk("rst_wbv", 32'(wb_valid), 0);
        look("rst_s5", 8'd5, 2'b00, 2'b00, 1'b0);

        // Round-robin victim on set 3
        upd(8'd3, 1'b0, 2'b00);           // rr 0->1
        look("fill30", 8'd3, 2'b01, 2'b00, 1'b1);
        upd(8'd3, 1'b1, 2'b00);           // rr 1->0
        look("fill31", 8'd3, 2'b11, 2'b00, 1'b0);
        upd(8'd3, 1'b0, 2'b00);           // rr 0->1
        look("fill30b", 8'd3, 2'b11, 2'b00, 1'b1);
        upd(8'd3, 1'b0, 2'b00);           // way != rr: rr stays 1
        look("fill30c", 8'd3, 2'b11, 2'b00, 1'b1);
        upd(8'd3, 1'b1, 2'b11);
        look("inv31", 8'd3, 2'b01, 2'b00, 1'b1);
        upd(8'd3, 1'b1, 2'b00);           // rr 1->0
        look("refill31", 8'd3, 2'b11, 2'b00, 1'b0);

        // Dirty marking on set 7
        upd(8'd7, 1'b1, 2'b01);
        look("dirty_inv", 8'd7, 2'b00, 2'b00, 1'b0);
        upd(8'd7, 1'b1, 2'b00);
        upd_en = 1'b1; upd_set = 8'd7; upd_way = 1'b1; upd_op = 2'b01;
        lk_set = 8'd7;
        #1;
        chk("no_bypass", 32'(lk_dirty), 0);
        tick();
        upd_en = 1'b0;
        look("dirty71", 8'd7, 2'b10, 2'b10, 1'b0);
        upd(8'd7, 1'b1, 2'b10);
        look("clean71", 8'd7, 2'b10, 2'b00, 1'b0);
        upd(8'd7, 1'b1, 2'b01);
        upd(8'd7, 1'b1, 2'b11);
        look("inv71", 8'd7, 2'b00, 2'b00, 1'b0);

        // Flush with invalidate and three dirty lines
        upd(8'd2, 1'b0, 2'b00); upd(8'd2, 1'b1, 2'b00); upd(8'd200, 1'b1, 2'b00);
        upd(8'd2, 1'b0, 2'b01); upd(8'd2, 1'b1, 2'b01); upd(8'd200, 1'b1, 2'b01);
        upd(8'd9, 1'b0, 2'b00);
        flush_start = 1'b1; flush_inv = 1'b1;
        tick();
        flush_start = 1'b0; flush_inv = 1'b0;
        n_wb = 0; n_done = 0; wb_cnt = 0;
        for (int c = 0; c < 3000 && n_done == 0; c++) begin
            if (wb_valid) begin
                if (n_wb < 3) begin
                    chk("wb_set", 32'(wb_set), 32'(exp_set[n_wb]));
                    chk("wb_way", 32'(wb_way), 32'(exp_way[n_wb]));
                end else begin
                    chk("wb_extra", 32'(n_wb), 3);
                end
                if (wb_cnt == 3) begin
                    wb_ready = 1'b1; n_wb++; wb_cnt = 0;
                end else begin
                    wb_cnt++;
                end
            end
            if (flush_done) n_done++;
            else tick();
            wb_ready = 1'b0;
        end
        chk("wb_count", 32'(n_wb), 3);
        chk("flush_done_seen", 32'(n_done), 1);
        seen = 0;
        for (int c = 0; c < 5; c++) begin
            tick();
            if (flush_done || wb_valid) seen++;
        end
        chk("done_single", 32'(seen), 0);
        chk("busy_after", 32'(flush_busy), 0);
        look("fl_s2", 8'd2, 2'b00, 2'b00, 1'b0);
        look("fl_s200", 8'd200, 2'b00, 2'b00, 1'b0);
        look("fl_s3", 8'd3, 2'b00, 2'b00, 1'b0);
        look("fl_s9", 8'd9, 2'b00, 2'b00, 1'b0);

        // Clean flush timing, updates and restart ignored while busy
        upd(8'd50, 1'b0, 2'b00);
        flush_start = 1'b1; flush_inv = 1'b0;
        tick();
        flush_start = 1'b0;
        n = 1;
        while (!flush_done && n < 400) begin
            if (n == 10) begin upd_en = 1'b1; upd_set = 8'd50; upd_way = 1'b0; upd_op = 2'b01; end
            if (n == 20) begin upd_en = 1'b1; upd_set = 8'd50; upd_way = 1'b0; upd_op = 2'b11; end
            if (n == 30) begin flush_start = 1'b1; flush_inv = 1'b1; end
            tick();
            upd_en = 1'b0; flush_start = 1'b0; flush_inv = 1'b0;
            n++;
        end
        chk("flush_len", 32'(n), 257);
        tick();
        chk("idle_after", 32'(flush_done | flush_busy), 0);
        look("fl_s50", 8'd50, 2'b01, 2'b00, 1'b1);

        // Reset during writeback
        upd(8'd5, 1'b1, 2'b00); upd(8'd5, 1'b1, 2'b01);
        flush_start = 1'b1; flush_inv = 1'b1;
        tick();
        flush_start = 1'b0; flush_inv = 1'b0;
        seen = 0;
        for (int c = 0; c < 300 && !wb_valid; c++) tick();
        chk("wb_before_rst", 32'(wb_valid), 1);
        chk("wb_set_rst", 32'(wb_set), 5);
        wb_ready = 1'b1; reset = 1'b1;
        tick();
        wb_ready = 1'b0; reset = 1'b0;
        chk("rst_wb_valid", 32'(wb_valid), 0);
        chk("rst_wb_busy", 32'(flush_busy), 0);
        for (int c = 0; c < 300; c++) begin
            if (flush_done || wb_valid) seen++;
            tick();
        end
        chk("no_done_after_rst", 32'(seen), 0);
        look("rst_s5b", 8'd5, 2'b00, 2'b00, 1'b0);
        look("rst_s50", 8'd50, 2'b00, 2'b00, 1'b0);

        // Reset wins over a same-cycle update
        upd_en = 1'b1; upd_set = 8'd6; upd_way = 1'b0; upd_op = 2'b00; reset = 1'b1;
        tick();
        upd_en = 1'b0; reset = 1'b0;
        look("rst_vs_upd", 8'd6, 2'b00, 2'b00, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
